// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (receiver states, data size, default oversampling)
package uart_pkg;
    localparam int DATA_SIZE      = 8;
    localparam int OVERSAMPLE_DEF = 16;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: pointer/array show-ahead FIFO, 2^PTR_W entries with one left unused to tell full from empty
module uart_fifo
    import uart_pkg::*;
#(
    parameter int PTR_W = 5,
    parameter int W     = DATA_SIZE
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    logic [W-1:0]     queue [2**PTR_W];
    logic [PTR_W-1:0] write_ptr, read_ptr;
    logic             do_push, do_pop;
    assign empty_o = read_ptr == write_ptr;
    assign full_o  = PTR_W'(write_ptr + 1'b1) == read_ptr;
    assign dout_o  = queue[read_ptr];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            write_ptr <= '0;
            read_ptr  <= '0;
        end else begin
            if (do_push) write_ptr <= write_ptr + 1'b1;
            if (do_pop)  read_ptr  <= read_ptr + 1'b1;
        end
    end
    // storage is deliberately left out of reset
    always_ff @(posedge clk_i) begin
        if (do_push) queue[write_ptr] <= din_i;
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver sampling on an oversampled tick, bytes queued in a show-ahead FIFO
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int PTR_W      = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 uart_sample_pulse_i,
    input  logic                 rx_i,
    input  logic                 re_i,
    output logic [DATA_SIZE-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 frame_err_o,
    output logic                 overrun_o
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] MID = CNT_W'(OVERSAMPLE / 2 - 1);
    logic [1:0]           sync;
    logic                 rx_s;
    rx_state_t            state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [2:0]           bit_idx, idx_n;
    logic [DATA_SIZE-1:0] sh, sh_n;
    logic                 push, ferr, ovr;
    assign rx_s = sync[1];
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync        <= 2'b11;
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            sh          <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            sync        <= {sync[0], rx_i};
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= idx_n;
            sh          <= sh_n;
            frame_err_o <= ferr;
            overrun_o   <= ovr;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = bit_idx;
        sh_n    = sh;
        push    = 1'b0;
        ferr    = 1'b0;
        ovr     = 1'b0;
        if (uart_sample_pulse_i) begin
            case (state)
                IDLE: begin
                    cnt_n   = '0;
                    state_n = rx_s ? IDLE : START;
                end
                START: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == MID) begin
                        cnt_n   = '0;
                        idx_n   = '0;
                        state_n = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    cnt_n = cnt + 1'b1;
                    if (&cnt) begin
                        sh_n    = {rx_s, sh[DATA_SIZE-1:1]};
                        idx_n   = bit_idx + 1'b1;
                        state_n = bit_idx == 3'd7 ? STOP : DATA;
                    end
                end
                STOP: begin
                    cnt_n = cnt + 1'b1;
                    // leave at mid stop bit so a back-to-back start edge is not missed
                    if (&cnt) begin
                        state_n = IDLE;
                        push    = rx_s & ~full_o;
                        ovr     = rx_s & full_o;
                        ferr    = ~rx_s;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
    uart_fifo #(.PTR_W(PTR_W), .W(DATA_SIZE)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .din_i   (sh),
        .pop_i   (re_i),
        .dout_o  (data_o),
        .full_o  (full_o),
        .empty_o (empty_o)
    );
endmodule
